mxn_pipe: RTL



---
 rtl/mxn_pipe.sv | 88 ++++++++
 1 files changed

// File: rtl/mxn_pipe.sv
// mxn_pipe: registered N:1 word mux with explicit or round-robin select and a valid/ready handshake.
//   Define MXN_PIPE_SKID_EN to add a one-entry skid buffer (registered in_ready).
//   clk, reset_n    : clock, asynchronous active-low reset
//   in_valid/ready  : input beat handshake
//   d               : N lanes of WIDTH bits, lane k = d[k*WIDTH +: WIDTH]
//   sel, mode       : explicit lane select (mode=0) or round-robin scan (mode=1)
//   out_valid/ready : output beat handshake
//   y, y_idx, y_err : selected word, its lane index, index-out-of-range flag
module mxn_pipe #(
  parameter int WIDTH = 32,
  parameter int N = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   d,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  output logic [SEL_W-1:0]     y_idx,
  output logic                 y_err
);
  logic [SEL_W-1:0] rr_ptr, idx;
  logic [WIDTH-1:0] word;
  logic             err, acc;
  assign idx = mode ? rr_ptr : sel;
  assign err = 32'(idx) >= 32'(N);
  assign acc = in_valid && in_ready;
  // an index with no matching lane leaves word at zero
  always_comb begin
    word = '0;
    for (int k = 0; k < N; k++) word = (idx == SEL_W'(k)) ? d[k*WIDTH +: WIDTH] : word;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rr_ptr <= '0;
    else if (acc && mode) rr_ptr <= (rr_ptr == SEL_W'(N-1)) ? '0 : rr_ptr + 1'b1;
`ifdef MXN_PIPE_SKID_EN
  logic             skid_valid, skid_err;
  logic [WIDTH-1:0] skid_y;
  logic [SEL_W-1:0] skid_idx;
  assign in_ready = !skid_valid;
  // skid fills only while the output is stalled; it always drains before a new accept
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid  <= 1'b0;
      y          <= '0;
      y_idx      <= '0;
      y_err      <= 1'b0;
      skid_valid <= 1'b0;
      skid_y     <= '0;
      skid_idx   <= '0;
      skid_err   <= 1'b0;
    end else if (skid_valid && out_ready) begin
      y          <= skid_y;
      y_idx      <= skid_idx;
      y_err      <= skid_err;
      skid_valid <= 1'b0;
    end else if (acc && (!out_valid || out_ready)) begin
      out_valid <= 1'b1;
      y         <= word;
      y_idx     <= idx;
      y_err     <= err;
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_y     <= word;
      skid_idx   <= idx;
      skid_err   <= err;
    end else if (out_ready) out_valid <= 1'b0;
`else
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_idx     <= '0;
      y_err     <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      y         <= word;
      y_idx     <= idx;
      y_err     <= err;
    end else if (out_ready) out_valid <= 1'b0;
`endif
endmodule
